// File: rtl/sr_fifo_param.sv
// Parametrised synchronous FIFO for sr_cpu: any depth >= 2, show-ahead or
// registered read, occupancy thresholds, flush and sticky error flags.
module sr_fifo_param #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH         = 8,
   parameter bit          SHOW_AHEAD    = 1'b1,
   parameter int unsigned AFULL_THRESH  = DEPTH - 1,
   parameter int unsigned AEMPTY_THRESH = 1,
   localparam int unsigned CW           = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  writeEnable,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  readEnable,
   output logic [DATA_WIDTH-1:0] readData,
   input  logic                  flush,
   input  logic                  clearErr,
   output logic                  full,
   output logic                  empty,
   output logic                  almostFull,
   output logic                  almostEmpty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  ovf_set;
   logic                  udf_set;

   // Status comes only from the registered occupancy
   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign almostFull  = (32'(count) >= AFULL_THRESH);
   assign almostEmpty = (32'(count) <= AEMPTY_THRESH);

   // Accept/error decode; a flush cycle accepts nothing and flags nothing
   always_comb begin
      push_ok = 1'b0;
      pop_ok  = 1'b0;
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (!flush) begin
         push_ok = writeEnable & (~full | readEnable);
         pop_ok  = readEnable & ~empty;
         ovf_set = writeEnable & full & ~readEnable;
         udf_set = readEnable & empty;
      end
   end

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // A fresh error in the clearing cycle keeps the flag set
         overflow  <= ovf_set | (overflow & ~clearErr);
         underflow <= udf_set | (underflow & ~clearErr);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
         end
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= writeData;
   end

   generate
      if (SHOW_AHEAD) begin : g_show_ahead
         assign readData = empty ? '0 : mem[rd_ptr];
      end else begin : g_registered
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      readData <= '0;
            else if (pop_ok) readData <= mem[rd_ptr];
         end
      end
   endgenerate

endmodule

// File: tb/tb_sr_fifo_param.sv
// Bench for sr_fifo_param: three configurations share one stimulus stream and
// are checked every cycle against a queue-based model plus literal checkpoints.
module tb_sr_fifo_param;

   localparam int unsigned DW = 8;
   localparam int NI = 3;
   localparam int DEP [NI] = '{4, 3, 5};
   localparam bit SA  [NI] = '{1'b1, 1'b1, 1'b0};
   localparam int AF  [NI] = '{3, 2, 3};
   localparam int AE  [NI] = '{1, 1, 2};

   logic          clk         = 1'b0;
   logic          rst_n       = 1'b0;
   logic          writeEnable = 1'b0;
   logic          readEnable  = 1'b0;
   logic          flush       = 1'b0;
   logic          clearErr    = 1'b0;
   logic [DW-1:0] writeData   = '0;

   wire [DW-1:0]  rd0, rd1, rd2;
   wire [2:0]     cnt0, cnt2;
   wire [1:0]     cnt1;
   wire [NI-1:0]  full_v, empty_v, afull_v, aempty_v, ovf_v, udf_v;

   logic [31:0]   g_rd  [NI];
   logic [31:0]   g_cnt [NI];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sr_fifo_param #(.DATA_WIDTH(DW), .DEPTH(4), .SHOW_AHEAD(1'b1)) u_d4 (
      .clk(clk), .rst_n(rst_n), .writeEnable(writeEnable), .writeData(writeData),
      .readEnable(readEnable), .readData(rd0), .flush(flush), .clearErr(clearErr),
      .full(full_v[0]), .empty(empty_v[0]), .almostFull(afull_v[0]),
      .almostEmpty(aempty_v[0]), .count(cnt0), .overflow(ovf_v[0]), .underflow(udf_v[0]));

   sr_fifo_param #(.DATA_WIDTH(DW), .DEPTH(3), .SHOW_AHEAD(1'b1)) u_d3 (
      .clk(clk), .rst_n(rst_n), .writeEnable(writeEnable), .writeData(writeData),
      .readEnable(readEnable), .readData(rd1), .flush(flush), .clearErr(clearErr),
      .full(full_v[1]), .empty(empty_v[1]), .almostFull(afull_v[1]),
      .almostEmpty(aempty_v[1]), .count(cnt1), .overflow(ovf_v[1]), .underflow(udf_v[1]));

   sr_fifo_param #(.DATA_WIDTH(DW), .DEPTH(5), .SHOW_AHEAD(1'b0),
                   .AFULL_THRESH(3), .AEMPTY_THRESH(2)) u_d5 (
      .clk(clk), .rst_n(rst_n), .writeEnable(writeEnable), .writeData(writeData),
      .readEnable(readEnable), .readData(rd2), .flush(flush), .clearErr(clearErr),
      .full(full_v[2]), .empty(empty_v[2]), .almostFull(afull_v[2]),
      .almostEmpty(aempty_v[2]), .count(cnt2), .overflow(ovf_v[2]), .underflow(udf_v[2]));

   always_comb begin
      g_rd[0]  = 32'(rd0);
      g_rd[1]  = 32'(rd1);
      g_rd[2]  = 32'(rd2);
      g_cnt[0] = 32'(cnt0);
      g_cnt[1] = 32'(cnt1);
      g_cnt[2] = 32'(cnt2);
   end

   task automatic check(input string name, input int i, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s inst%0d t=%0t got=0x%0h expected=0x%0h",
                    name, i, $time, got, exp);
   endtask

   // Reference model: one queue per configuration
   logic [DW-1:0] mq [NI][$];
   logic [DW-1:0] m_rd  [NI] = '{default: '0};
   logic          m_ovf [NI] = '{default: 1'b0};
   logic          m_udf [NI] = '{default: 1'b0};
   logic [DW-1:0] popped;
   int            msz;
   bit            m_full, m_empty;

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            mq[i].delete();
            m_rd[i]  = '0;
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
         end else begin
            msz     = mq[i].size();
            m_full  = (msz == DEP[i]);
            m_empty = (msz == 0);
            if (!flush && writeEnable && m_full && !readEnable) m_ovf[i] = 1'b1;
            else if (clearErr)                                  m_ovf[i] = 1'b0;
            if (!flush && readEnable && m_empty) m_udf[i] = 1'b1;
            else if (clearErr)                   m_udf[i] = 1'b0;
            if (flush) mq[i].delete();
            else begin
               if (readEnable && !m_empty) begin
                  popped = mq[i].pop_front();
                  if (!SA[i]) m_rd[i] = popped;
               end
               if (writeEnable && (!m_full || readEnable)) mq[i].push_back(writeData);
            end
         end
      end
   end

   // Every-cycle comparison against the model
   int          csz;
   logic [31:0] exp_rd;

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         csz = mq[i].size();
         if (SA[i]) exp_rd = (csz != 0) ? 32'(mq[i][0]) : 32'h0;
         else       exp_rd = 32'(m_rd[i]);
         check("count",       i, g_cnt[i],           32'(csz));
         check("full",        i, 32'(full_v[i]),     32'(csz == DEP[i]));
         check("empty",       i, 32'(empty_v[i]),    32'(csz == 0));
         check("almostFull",  i, 32'(afull_v[i]),    32'(csz >= AF[i]));
         check("almostEmpty", i, 32'(aempty_v[i]),   32'(csz <= AE[i]));
         check("overflow",    i, 32'(ovf_v[i]),      32'(m_ovf[i]));
         check("underflow",   i, 32'(udf_v[i]),      32'(m_udf[i]));
         check("readData",    i, g_rd[i],            exp_rd);
      end
   end

   task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re,
                        input bit fl, input bit ce);
      writeEnable = we;
      writeData   = wd;
      readEnable  = re;
      flush       = fl;
      clearErr    = ce;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      readEnable  = 1'b0;
      flush       = 1'b0;
      clearErr    = 1'b0;
   endtask

   logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [DW-1:0] tail [4] = '{8'h22, 8'h33, 8'h44, 8'hAA};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty",  0, 32'(empty_v[0]),  32'h1);
      check("rst_full",   0, 32'(full_v[0]),   32'h0);
      check("rst_count",  0, g_cnt[0],         32'h0);
      check("rst_aempty", 0, 32'(aempty_v[0]), 32'h1);
      check("rst_afull",  0, 32'(afull_v[0]),  32'h0);
      check("rst_rdata",  2, g_rd[2],          32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full, then a lone push must be rejected
      for (int k = 0; k < 4; k++) drive(1'b1, vals[k], 1'b0, 1'b0, 1'b0);
      check("fill_count", 0, g_cnt[0],         32'h4);
      check("fill_full",  0, 32'(full_v[0]),   32'h1);
      check("fill_afull", 0, 32'(afull_v[0]),  32'h1);
      check("d3_ovf",     1, 32'(ovf_v[1]),    32'h1);
      check("d5_count",   2, g_cnt[2],         32'h4);
      check("d5_full",    2, 32'(full_v[2]),   32'h0);
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      check("ovf_set",    0, 32'(ovf_v[0]),    32'h1);
      check("ovf_count",  0, g_cnt[0],         32'h4);
      check("d5_full5",   2, 32'(full_v[2]),   32'h1);

      for (int k = 0; k < 4; k++) begin
         check("sa_pop_data", 0, g_rd[0], 32'(vals[k]));
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         if (k == 0) check("reg_pop_data", 2, g_rd[2], 32'h11);
      end
      check("drain_empty", 0, 32'(empty_v[0]), 32'h1);
      check("drain_rdata", 0, g_rd[0],         32'h0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("no_55_seen",  0, g_rd[0],         32'h0);
      check("reg_last",    2, g_rd[2],         32'h55);
      check("udf_set",     0, 32'(udf_v[0]),   32'h1);

      // Full with simultaneous push and pop
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      check("flush_clr_ovf", 0, 32'(ovf_v[0]), 32'h0);
      for (int k = 0; k < 4; k++) drive(1'b1, vals[k], 1'b0, 1'b0, 1'b0);
      check("pp_head", 0, g_rd[0], 32'h11);
      drive(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      check("pp_count", 0, g_cnt[0],       32'h4);
      check("pp_ovf",   0, 32'(ovf_v[0]),  32'h0);
      for (int k = 0; k < 4; k++) begin
         check("pp_tail", 0, g_rd[0], 32'(tail[k]));
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end

      // Underflow with clear in the same cycle as a new error
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("udf_empty_pop", 0, 32'(udf_v[0]), 32'h1);
      check("udf_count0",    0, g_cnt[0],      32'h0);
      drive(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      check("udf_new_wins",  0, 32'(udf_v[0]), 32'h1);
      check("udf_count1",    0, g_cnt[0],      32'h1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("udf_cleared",   0, 32'(udf_v[0]), 32'h0);
      check("no_bypass",     0, g_rd[0],       32'h7);

      // Registered read mode, flush holding readData, async reset
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("reg_c0",        2, g_rd[2],       32'hC0);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("flush_count",   2, g_cnt[2],      32'h0);
      check("flush_hold",    2, g_rd[2],       32'hC0);
      check("flush_no_udf",  2, 32'(udf_v[2]), 32'h0);
      drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      check("pre_rst_nonempty", 0, 32'(empty_v[0]), 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("async_empty0", 0, 32'(empty_v[0]), 32'h1);
      check("async_empty2", 2, 32'(empty_v[2]), 32'h1);
      check("async_count0", 0, g_cnt[0],        32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Depth 3 wrap: outputs 1..10 with occupancy at most 2
      drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      for (int k = 3; k <= 10; k++) begin
         check("wrap_data", 1, g_rd[1], 32'(k - 2));
         drive(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
         check("wrap_count", 1, g_cnt[1], 32'h2);
      end
      check("wrap_data", 1, g_rd[1], 32'd9);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("wrap_data", 1, g_rd[1], 32'd10);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("wrap_empty", 1, 32'(empty_v[1]), 32'h1);

      // Random traffic with alternating fill/drain bias
      for (int n = 0; n < 3000; n++) begin
         writeEnable = ($urandom_range(99) < ((((n / 150) % 2) == 0) ? 70 : 30));
         readEnable  = ($urandom_range(99) < ((((n / 150) % 2) == 0) ? 30 : 70));
         writeData   = 8'($urandom);
         flush       = ($urandom_range(63) == 0);
         clearErr    = ($urandom_range(15) == 0);
         @(posedge clk);
         #1;
         if (n == 1700) begin
            #2 rst_n = 1'b0;
            #1;
            for (int i = 0; i < NI; i++) check("rand_async_empty", i, 32'(empty_v[i]), 32'h1);
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
      end
      writeEnable = 1'b0;
      readEnable  = 1'b0;
      flush       = 1'b0;
      clearErr    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sr_fifo_param.md
Name: sr_fifo_param

Overview:
Parametrised synchronous FIFO, successor to the fixed CPU-attached FIFO. It is reached by the FIFO push/pop instructions of sr_cpu.
- Generalised in data width and depth (any depth ≥2, not only powers of two).
- Selectable show-ahead or registered read mode.
- Adds occupancy count, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags for software polling.

Parameters:
DATA_WIDTH, 32, width of each entry in bits
DEPTH, 8, number of entries; ≥2, any integer
SHOW_AHEAD, 1, 1 = readData shows head entry combinationally (single-cycle CPU pop); 0 = readData registered, valid the cycle after an accepted pop
AFULL_THRESH, DEPTH-1, almostFull asserted when count ≥ AFULL_THRESH
AEMPTY_THRESH, 1, almostEmpty asserted when count ≤ AEMPTY_THRESH

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
writeEnable  in  1  push request
writeData  in  DATA_WIDTH  push data
readEnable  in  1  pop request
readData  out  DATA_WIDTH  head/popped data
flush  in  1  synchronous discard of all entries
clearErr  in  1  synchronous clear of sticky error flags
full  out  1  count == DEPTH
empty  out  1  count == 0
almostFull  out  1  count ≥ AFULL_THRESH
almostEmpty  out  1  count ≤ AEMPTY_THRESH
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: push was rejected
underflow  out  1  sticky: pop was rejected

Behaviour:
- Reset (rst_n low, async):
  - wrPtr, rdPtr and count are 0.
  - overflow and underflow are 0; registered readData is 0.
  - Outputs: empty=1, full=0, almostEmpty=1, almostFull=(AFULL_THRESH==0).
  - Storage array is not reset.
- Pointers: 0..DEPTH-1, increment with explicit wrap DEPTH-1 → 0. No power-of-two arithmetic.
- Status flags and count are derived from registered count only. They are never combinational from writeEnable/readEnable.
- Accept rules, evaluated each edge when flush=0:
  - pushOk = writeEnable & (!full | readEnable).
  - popOk = readEnable & !empty.
  - Full with push+pop: both accepted, count unchanged, the popped entry is the old head.
  - Empty with push+pop: push accepted, pop rejected (underflow set), count becomes 1. There is no bypass.
- count next = count + pushOk − popOk.
- Write: on pushOk, mem[wrPtr] ← writeData and wrPtr advances.
- Pop: on popOk, rdPtr advances.
- SHOW_AHEAD=1:
  - readData = mem[rdPtr] when !empty, else 0 (combinational).
  - The CPU captures readData in the same cycle it asserts readEnable.
- SHOW_AHEAD=0:
  - On popOk, the readData register ← mem[rdPtr], visible after the edge.
  - readData holds its value otherwise, including on a rejected pop or a flush.
- Errors:
  - overflow sets on writeEnable & full & !readEnable.
  - underflow sets on readEnable & empty.
  - Both are sticky until clearErr.
  - If clearErr and a new error occur in the same cycle, the flag ends set.
- Flush:
  - Has priority over push/pop in the same cycle.
  - wrPtr, rdPtr and count go to 0; push/pop that cycle are ignored and raise no error.
  - Sticky flags are unaffected unless clearErr is also high.
- Reset mid-operation: all content is logically lost. empty=1 is visible immediately, asynchronously.
- Latency: push to non-empty visible after 1 edge. In show-ahead mode, pushed data reaches readData 1 cycle after the push when the FIFO was empty.

Test Plan:
- DEPTH=4, SHOW_AHEAD=1: push 0x11,0x22,0x33,0x44 → full=1, count=4, almostFull=1. Pops return 0x11,0x22,0x33,0x44 in order, then empty=1, readData=0.
- DEPTH=4, full: push 0x55 alone → overflow=1, count stays 4. Pops yield 0x11..0x44; 0x55 is never seen.
- DEPTH=3 (non-power-of-two): 10 interleaved push/pop of values 1..10, occupancy ≤2 → pointers wrap correctly, output sequence is 1..10, count never exceeds 3.
- Full DEPTH=4, simultaneous push 0xAA + pop → pop returns the oldest entry, count stays 4. After 4 more pops the last value is 0xAA.
- Empty: pop → underflow=1, count 0. Then push 0x7 with clearErr=1 and readEnable=1 in the same cycle → underflow remains 1 (new error wins), count=1. Next cycle clearErr alone → underflow=0.
- SHOW_AHEAD=0, 2 entries 0xC0,0xC1: pop → readData=0xC0 one cycle later. Then flush with readEnable high → count=0, readData holds 0xC0, no underflow. Then assert rst_n=0 mid-cycle → empty=1 immediately.
